// File: rtl/lct_daq_buffer.sv
// LCT pair DAQ buffer: every BX the {best,second} LCT pair goes into a circular pipeline RAM; an L1A
// copies a window of past BXs into an output FIFO. Define LCT_ZSUP_EN to drop BXs with no valid LCT.
module lct_daq_buffer #(
    parameter int DEPTH_LOG2 = 7,
    parameter int FIFO_LOG2  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hv,
    input  logic                  lv,
    input  logic [1:0]            hp,
    input  logic [1:0]            lp,
    input  logic [6:0]            hnp,
    input  logic [6:0]            lnp,
    input  logic                  hfap,
    input  logic                  lfap,
    input  logic                  hpatbp,
    input  logic                  lpatbp,
    input  logic                  l1a,
    input  logic [DEPTH_LOG2-1:0] l1a_delay,
    input  logic [3:0]            win_len,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [27:0]           out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  l1a_drop
);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int FDEPTH = 1 << FIFO_LOG2;

    typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;
    state_t state, state_nxt;

    logic [23:0]           ram [DEPTH];
    logic [23:0]           pair, ram_q;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, d_eff;
    logic [3:0]            w_eff, w_q, rd_cnt, dat_idx;
    logic                  dat_vld, accept, rd_en;
    logic                  push, pop, push_last;
    logic [27:0]           push_word;
    logic [28:0]           fmem [FDEPTH];
    logic [FIFO_LOG2-1:0]  f_wp, f_rp;
    logic [FIFO_LOG2:0]    f_cnt, f_free;

    assign pair   = {hv, hp, hnp, hfap, hpatbp, lv, lp, lnp, lfap, lpatbp};
    // Clamp keeps the last window read one slot behind the write pointer.
    assign d_eff  = (l1a_delay > DEPTH_LOG2'(DEPTH - 2)) ? DEPTH_LOG2'(DEPTH - 2) : l1a_delay;
    assign w_eff  = (win_len == 4'd0) ? 4'd1 : win_len;
    assign f_free = (FIFO_LOG2 + 1)'(FDEPTH) - f_cnt;
    assign accept = (state == IDLE) && l1a && (int'(f_free) >= int'(w_eff));
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) ram[wr_ptr] <= pair;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wr_ptr <= '0;
        else        wr_ptr <= wr_ptr + 1'b1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE:  if (accept) state_nxt = READ;
            READ: begin
                rd_en = 1'b1;
                if (rd_cnt == w_q - 4'd1) state_nxt = FLUSH;
            end
`ifdef LCT_ZSUP_EN
            // Wait for the last read word, then emit the held word in the following cycle.
            FLUSH: if (!dat_vld) state_nxt = IDLE;
`else
            FLUSH: state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_ptr   <= '0;
            rd_cnt   <= '0;
            w_q      <= 4'd1;
            dat_vld  <= 1'b0;
            dat_idx  <= '0;
            l1a_drop <= 1'b0;
        end else begin
            dat_vld <= rd_en;
            dat_idx <= rd_cnt;
            if (accept) begin
                rd_ptr <= wr_ptr - d_eff;
                rd_cnt <= '0;
                w_q    <= w_eff;
            end else if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (l1a && !accept) l1a_drop <= 1'b1;
        end

    always_ff @(posedge clk) if (rd_en) ram_q <= ram[rd_ptr];

`ifdef LCT_ZSUP_EN
    // One-word hold lets out_last land on the final non-empty BX of the window.
    logic [27:0] hold;
    logic        hold_vld, nz, fin;

    assign nz  = ram_q[23] | ram_q[11];
    assign fin = (state == FLUSH) && !dat_vld;

    always_comb begin
        push      = (dat_vld && nz && hold_vld) || fin;
        push_word = hold;
        if (fin && !hold_vld) push_word = {4'hF, 24'h0};
        push_last = fin;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hold     <= '0;
            hold_vld <= 1'b0;
        end else if (accept) begin
            hold_vld <= 1'b0;
        end else if (dat_vld && nz) begin
            hold     <= {dat_idx, ram_q};
            hold_vld <= 1'b1;
        end
`else
    logic dat_last;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dat_last <= 1'b0;
        else        dat_last <= rd_en && (rd_cnt == w_q - 4'd1);

    assign push      = dat_vld;
    assign push_word = {dat_idx, ram_q};
    assign push_last = dat_last;
`endif

    // Admission reserves W slots up front, so a push never meets a full FIFO.
    assign out_valid = (f_cnt != '0);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) if (push) fmem[f_wp] <= {push_last, push_word};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            f_wp  <= '0;
            f_rp  <= '0;
            f_cnt <= '0;
        end else begin
            if (push) f_wp <= f_wp + 1'b1;
            if (pop)  f_rp <= f_rp + 1'b1;
            case ({push, pop})
                2'b10:   f_cnt <= f_cnt + 1'b1;
                2'b01:   f_cnt <= f_cnt - 1'b1;
                default: ;
            endcase
        end

    assign {out_last, out_data} = out_valid ? fmem[f_rp] : '0;
endmodule

// File: doc/lct_daq_buffer.md
Name: lct_daq_buffer

Overview:
- DAQ-side consumer of the per-BX LCT pair from the trigger core: the best LCT (hv/hp/hnp/hfap/hpatbp) and the second LCT (lv/lp/lnp/lfap/lpatbp).
- Every clock the pair is written into a circular BX pipeline RAM.
- On L1A, a programmable window of BXs starting l1a_delay BXs in the past is read back into an output FIFO.
- The FIFO drains over a valid/ready word interface toward the readout formatter.

Parameters:
DEPTH_LOG2, 7, BX pipeline depth = 2^DEPTH_LOG2 entries (128)
FIFO_LOG2, 5, output FIFO depth = 2^FIFO_LOG2 words (32)

Ports:
clk  in  1  system clock, one BX per cycle
rst_n  in  1  asynchronous active-low reset
hv, lv  in  1 each  best/second LCT valid
hp, lp  in  2 each  best/second quality
hnp, lnp  in  7 each  best/second key wiregroup
hfap, lfap  in  1 each  accelerator flag
hpatbp, lpatbp  in  1 each  pattern-b flag
l1a  in  1  level-1 accept strobe, one cycle
l1a_delay  in  DEPTH_LOG2  BX offset from l1a back to window start
win_len  in  4  window length in BX; 0 treated as 1
out_ready  in  1  downstream accepts word
out_valid  out  1  out_data valid
out_data  out  28  [27:24] window index, [23:12] best LCT {v,q[1:0],key[6:0],fa,pb}, [11:0] second LCT, same layout
out_last  out  1  final word of an L1A event
busy  out  1  readout state machine not IDLE
l1a_drop  out  1  sticky: an l1a was rejected

Behaviour:
- Reset: all outputs 0; wr_ptr, FIFO pointers and state cleared; RAM contents don't-care. Reset mid-readout aborts the event and flushes the FIFO; no partial event survives.
- Write side:
  - Every clk the 24-bit pair {best,second} present in cycle t is written at wr_ptr.
  - wr_ptr increments mod 2^DEPTH_LOG2, independent of readout.
- Effective delay: d = min(l1a_delay, 2^DEPTH_LOG2-2). This prevents read/write address collision; 127 is clamped to 126.
- Effective length: W = (win_len==0) ? 1 : win_len.
- FSM IDLE:
  - l1a=1 with FIFO free count >= W: latch rd_ptr = wr_ptr - d (mod depth), idx=0, go READ.
  - Otherwise the l1a is ignored and l1a_drop is set (sticky until reset).
- FSM READ:
  - Issue one RAM read per clk (read latency 1).
  - Read data is pushed the next cycle with index idx; out_last=1 on idx==W-1.
  - After W reads go FLUSH.
- FSM FLUSH: the final push completes; return to IDLE.
- busy=1 in READ and FLUSH. l1a arriving while busy is dropped and sets l1a_drop.
- Window index i holds the LCT pair present at clk cycle T-d+i, where T is the l1a cycle; d=0 is legal and returns T's own data.
- Latency: l1a at T, RAM read T+1, FIFO push T+2, out_valid T+3 when the FIFO was empty.
- Output FIFO:
  - Registered output; a word transfers when out_valid & out_ready.
  - The admission check guarantees no push stalls. Simultaneous push and pop is allowed, with count unchanged.
  - Back-to-back events: the next l1a is accepted in the cycle after FLUSH if space allows.

Optional Feature:
- Macro LCT_ZSUP_EN.
- Defined: BX entries with hv=0 and lv=0 are not pushed. out_last goes on the last pushed word. If all W entries are suppressed, one word {idx=4'hF, 24'h0} with out_last=1 is pushed in FLUSH. The admission check is unchanged (W).
- Undefined: every BX in the window is pushed; no suppression logic is built.

Test Plan:
- Drive hv=1,hp=3,hnp=BX mod 128 each cycle; l1a at BX 200, l1a_delay=10, win_len=3 -> three words with keys 62,63,64 (BX 190-192), idx 0,1,2, out_last on idx 2, first out_valid at BX 203.
- l1a_delay=127 -> behaves as 126; l1a_delay=0, win_len=1 -> single word holding the l1a-cycle LCT.
- out_ready held low, repeated l1a with win_len=15, FIFO_LOG2=5 -> first two events accepted (30 words), third dropped, l1a_drop=1; release out_ready -> 30 words, out_last on words 15 and 30.
- l1a asserted during READ -> ignored, l1a_drop=1, current event intact.
- Assert rst_n=0 mid-READ -> out_valid=0, busy=0, FIFO empty; next l1a after release produces a complete event.
- With LCT_ZSUP_EN: window of 5 with LCTs only at idx 1,3 -> two words, out_last on idx 3; empty window -> one word 28'hF000000 with out_last=1.
